// File: rtl/hwpe_tcdm_responder.sv
// hwpe_tcdm_responder: multi-port TCDM slave and scratchpad.
// The word address space is interleaved over NB single-ported banks.
// Requests that conflict on a bank are arbitrated round-robin per bank.
// Grants are combinational. Responses arrive one cycle after the grant.
// Optional feature macro: HWPE_TCDM_RESP_STALL_EN. When it is defined, an
// LFSR withholds every grant on pseudo-random cycles.
module hwpe_tcdm_responder #(
  parameter int unsigned MP        = 3,
  parameter int unsigned NB        = 4,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  output logic [15:0]          err_cnt_o
);

  localparam int unsigned NBW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW     = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [31:0] NWORDS = 32'(NB * DEPTH);
  localparam logic [31:0] OOR_RD = 32'hBADA_CCE5;

  // Grants are possible only outside reset and outside a stall cycle.
  logic w_stall;
  logic w_go;
  assign w_go = ~rst_i & ~w_stall;

`ifdef HWPE_TCDM_RESP_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR with taps 16,14,13,11. It steps on every cycle that is not a reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b11);
`else
  assign w_stall = 1'b0;
`endif

  // Per-port address decode.
  logic [MP-1:0]  w_oor;
  logic [MP-1:0]  w_elig;
  logic [NBW-1:0] w_bank [MP];
  logic [RW-1:0]  w_row  [MP];
  logic [MP-1:0]  w_unused_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < MP; gi++) begin : g_dec
      logic [31:0] w_off;
      logic [31:0] w_word;
      assign w_off           = tcdm_add[gi] - BASE_ADDR;
      assign w_word          = {2'b00, w_off[31:2]};
      assign w_unused_lsb[gi] = ^w_off[1:0];
      assign w_oor[gi]       = (tcdm_add[gi] < BASE_ADDR) || (w_word >= NWORDS);
      assign w_bank[gi]      = NBW'(w_word % NB);
      assign w_row[gi]       = RW'(w_word / NB);
      // Out-of-range requests never compete for a bank.
      assign w_elig[gi]      = w_go & tcdm_req[gi] & ~w_oor[gi];
    end
  endgenerate

  // Per-bank arbitration, storage and read register.
  logic [NB-1:0] w_bank_any;
  logic [PW-1:0] w_bank_win   [NB];
  logic [31:0]   w_bank_rdata [NB];

  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      logic [PW-1:0] r_rr;
      logic [PW-1:0] w_win;
      logic          w_any;
      logic          w_we;
      logic          w_re;
      logic [RW-1:0] w_brow;
      logic [3:0]    w_bbe;
      logic [31:0]   w_bwdata;
      logic [31:0]   r_mem [DEPTH];
      logic [31:0]   r_rdata;

      // Pick the first eligible port at or after the pointer, wrapping around.
      always_comb begin
        int unsigned idx;
        w_win = '0;
        w_any = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < MP; k++) begin
          idx = (32'(r_rr) + k) % MP;
          if (!w_any && w_elig[idx] && (w_bank[idx] == NBW'(gi))) begin
            w_any = 1'b1;
            w_win = PW'(idx);
          end
        end
      end

      assign w_we     = w_any & ~tcdm_wen[w_win];
      assign w_re     = w_any &  tcdm_wen[w_win];
      assign w_brow   = w_row[w_win];
      assign w_bbe    = tcdm_be[w_win];
      assign w_bwdata = tcdm_data[w_win];

      // The pointer moves past the winner only on cycles that produce a grant.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rr <= '0;
        end else if (w_any) begin
          r_rr <= (w_win == PW'(MP - 1)) ? '0 : w_win + PW'(1);
        end
      end

      // Single-ported bank. Byte-masked writes are applied, and a read is registered one cycle later.
      always_ff @(posedge clk_i) begin
        if (w_we) begin
          for (int j = 0; j < 4; j++) begin
            if (w_bbe[j]) begin
              r_mem[w_brow][j*8 +: 8] <= w_bwdata[j*8 +: 8];
            end
          end
        end
        if (w_re) begin
          r_rdata <= r_mem[w_brow];
        end
      end

      assign w_bank_any[gi]   = w_any;
      assign w_bank_win[gi]   = w_win;
      assign w_bank_rdata[gi] = r_rdata;
    end
  endgenerate

  // Per-port grant and response path.
  generate
    for (gi = 0; gi < MP; gi++) begin : g_port
      logic           w_pgnt;
      logic           r_rv;
      logic           r_rd;
      logic           r_oor;
      logic [NBW-1:0] r_rbank;

      assign w_pgnt = w_bank_any[w_bank[gi]] && (w_bank_win[w_bank[gi]] == PW'(gi));
      assign tcdm_gnt[gi] = w_go & tcdm_req[gi] & (w_oor[gi] | w_pgnt);

      // Remember what the granted access was so the response can be formed next cycle.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rv    <= 1'b0;
          r_rd    <= 1'b0;
          r_oor   <= 1'b0;
          r_rbank <= '0;
        end else begin
          r_rv    <= tcdm_gnt[gi];
          r_rd    <= tcdm_wen[gi];
          r_oor   <= w_oor[gi];
          r_rbank <= w_bank[gi];
        end
      end

      // A response that is pending when reset is asserted is cancelled in that same cycle.
      assign tcdm_r_valid[gi] = r_rv & ~rst_i;
      assign tcdm_r_data[gi]  = (tcdm_r_valid[gi] & r_rd) ?
                                (r_oor ? OOR_RD : w_bank_rdata[r_rbank]) : 32'h0;
    end
  endgenerate

  // Saturating count of granted out-of-range accesses.
  logic [15:0] r_err;
  logic [31:0] w_err_sum;
  logic [MP-1:0] w_oor_gnt;
  assign w_oor_gnt = tcdm_gnt & w_oor;

  // Add every out-of-range access granted in this cycle to the running count.
  always_comb begin
    w_err_sum = {16'h0, r_err};
    for (int p = 0; p < MP; p++) begin
      w_err_sum = w_err_sum + {31'h0, w_oor_gnt[p]};
    end
  end

  // Hold the count at the top value instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 16'h0;
    end else begin
      r_err <= (w_err_sum > 32'h0000_FFFF) ? 16'hFFFF : w_err_sum[15:0];
    end
  end

  assign err_cnt_o = r_err;

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Bench for hwpe_tcdm_responder. It runs directed scenarios and then random traffic.
// A behavioural model of the memory, arbitration and error count supplies every expected value.
module tb_hwpe_tcdm_responder;

  localparam int MP    = 3;
  localparam int NB    = 4;
  localparam int DEPTH = 256;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] wdat;
  logic [MP-1:0][31:0] rdata;
  logic [MP-1:0]       rvalid;
  logic [15:0]         err_cnt;

  always #5 clk = ~clk;

  hwpe_tcdm_responder #(.MP(MP), .NB(NB), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add), .tcdm_wen(wen),
    .tcdm_be(be), .tcdm_data(wdat), .tcdm_r_data(rdata), .tcdm_r_valid(rvalid),
    .err_cnt_o(err_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] mem_m [NB*DEPTH];
  int          rr_m [NB];
  int          err_m;
  logic        exp_v [MP];
  logic [31:0] exp_d [MP];
  logic [15:0] lfsr_m;
  logic [31:0] obs_last [MP];
  int          grant_log [$];
  bit          saw_all;

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < NB*DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // One clock cycle. At the falling edge it checks the outputs against the model,
  // then advances the model across the next rising edge.
  task automatic cycle();
    logic [MP-1:0] g;
    bit stall;
    int b, d, w;
    @(negedge clk);
    for (int p = 0; p < MP; p++) begin
      check_val($sformatf("r_valid%0d", p), 32'(rvalid[p]), 32'(exp_v[p] & !rst));
      if (exp_v[p] && !rst) begin
        check_val($sformatf("r_data%0d", p), rdata[p], exp_d[p]);
        obs_last[p] = rdata[p];
      end
    end
    check_val("err_cnt", 32'(err_cnt), 32'(err_m));
    stall = 1'b0;
`ifdef HWPE_TCDM_RESP_STALL_EN
    stall = (lfsr_m[1:0] == 2'b11);
`endif
    g = '0;
    if (!rst && !stall) begin
      for (int p = 0; p < MP; p++) begin
        if (req[p]) begin
          if (!in_range(add[p])) begin
            g[p] = 1'b1;
          end else begin
            b = word_of(add[p]) % NB;
            d = (p - rr_m[b] + MP) % MP;
            g[p] = 1'b1;
            for (int q = 0; q < MP; q++) begin
              if (q != p && req[q] && in_range(add[q]) && (word_of(add[q]) % NB) == b &&
                  ((q - rr_m[b] + MP) % MP) < d) begin
                g[p] = 1'b0;
              end
            end
          end
        end
      end
    end
    check_val("gnt", 32'(gnt), 32'(g));
    if (g == {MP{1'b1}}) saw_all = 1'b1;
    for (int p = 0; p < MP; p++) begin
      if (g[p]) grant_log.push_back(p);
    end
    // Form the responses first. They use memory as it was before this cycle's writes.
    for (int p = 0; p < MP; p++) begin
      exp_v[p] = g[p];
      exp_d[p] = 32'h0;
      if (g[p] && wen[p]) begin
        exp_d[p] = in_range(add[p]) ? mem_m[word_of(add[p])] : 32'hBADA_CCE5;
      end
    end
    for (int p = 0; p < MP; p++) begin
      if (g[p] && !wen[p] && in_range(add[p])) begin
        w = word_of(add[p]);
        for (int j = 0; j < 4; j++) begin
          if (be[p][j]) mem_m[w][j*8 +: 8] = wdat[p][j*8 +: 8];
        end
      end
      if (g[p] && !in_range(add[p]) && err_m < 16'hFFFF) err_m++;
      if (g[p] && in_range(add[p])) rr_m[word_of(add[p]) % NB] = (p + 1) % MP;
    end
    if (rst) begin
      for (int i = 0; i < NB; i++) rr_m[i] = 0;
      for (int p = 0; p < MP; p++) exp_v[p] = 1'b0;
      err_m  = 0;
      lfsr_m = 16'hACE1;
    end else begin
`ifdef HWPE_TCDM_RESP_STALL_EN
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < MP; p++) begin
      if (g[p]) req[p] = 1'b0;
    end
  endtask

  task automatic set_port(input int p, input logic rd, input logic [31:0] a,
                          input logic [3:0] e, input logic [31:0] d);
    req[p]  = 1'b1;
    wen[p]  = rd;
    add[p]  = a;
    be[p]   = e;
    wdat[p] = d;
  endtask

  // Repeat cycles until every pending request is granted, then run one more cycle to check the last response.
  task automatic drain();
    int n = 0;
    while (req != '0 && n < 64) begin
      cycle();
      n++;
    end
    check_val("drain_timeout", 32'(req), 32'h0);
    req = '0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req = '0; wen = '0; add = '0; be = '0; wdat = '0;
    err_m = 0; lfsr_m = 16'hACE1; saw_all = 1'b0;
    for (int i = 0; i < NB; i++) rr_m[i] = 0;
    for (int p = 0; p < MP; p++) begin exp_v[p] = 1'b0; exp_d[p] = 32'h0; obs_last[p] = '1; end

    // Reset state. A request is present, but no grant may appear while reset is high.
    set_port(0, 1'b1, BASE, 4'hF, 32'h0);
    cycle();
    cycle();
    check_val("rst_gnt", 32'(gnt), 32'h0);
    check_val("rst_rvalid", 32'(rvalid), 32'h0);
    check_val("rst_rdata0", rdata[0], 32'h0);
    check_val("rst_err", 32'(err_cnt), 32'h0);
    req = '0;
    rst = 1'b0;

    // Prefill the working window, words 0..31.
    for (int i = 0; i < 32; i++) begin
      set_port(0, 1'b0, BASE + 32'(i*4), 4'hF, $urandom);
      drain();
    end

    // Write a word and read it back.
    set_port(0, 1'b0, BASE + 32'h10, 4'hF, 32'hCAFE_F00D);
    drain();
    check_val("cafe_wr_rdata", obs_last[0], 32'h0);
    set_port(0, 1'b1, BASE + 32'h10, 4'hF, 32'h0);
    drain();
    check_val("cafe_rd", obs_last[0], 32'hCAFE_F00D);

    // Byte enables.
    set_port(1, 1'b0, BASE + 32'h20, 4'hF, 32'h1122_3344);
    drain();
    set_port(1, 1'b0, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    drain();
    set_port(1, 1'b1, BASE + 32'h20, 4'hF, 32'h0);
    drain();
    check_val("be_rd", obs_last[1], 32'h11BB_33DD);

    // Out-of-range reads.
    set_port(1, 1'b1, BASE - 32'h4, 4'hF, 32'h0);
    drain();
    check_val("oor_lo", obs_last[1], 32'hBADA_CCE5);
    set_port(2, 1'b1, BASE + 32'(NB*DEPTH*4), 4'hF, 32'h0);
    drain();
    check_val("oor_hi", obs_last[2], 32'hBADA_CCE5);
    check_val("oor_err", 32'(err_cnt), 32'h2);

    // Assert reset in the cycle after a granted read.
    set_port(0, 1'b1, BASE + 32'h10, 4'hF, 32'h0);
    n = 0;
    while (req[0] && n < 64) begin cycle(); n++; end
    check_val("midrst_timeout", 32'(req[0]), 32'h0);
    rst = 1'b1;
    #1;
    check_val("midrst_rvalid", 32'(rvalid[0]), 32'h0);
    cycle();
    rst = 1'b0;
    cycle();
    check_val("midrst_err", 32'(err_cnt), 32'h0);

    // Bank conflict starting from fresh pointers. Every port keeps requesting bank 0.
    grant_log.delete();
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'(p*16), 4'hF, 32'h0);
    n = 0;
    while (grant_log.size() < 9 && n < 100) begin
      cycle();
      n++;
      for (int p = 0; p < MP; p++) begin
        if (!req[p]) set_port(p, 1'b1, BASE + 32'(p*16), 4'hF, 32'h0);
      end
    end
    req = '0;
    cycle();
    check_val("conf_cnt", 32'(grant_log.size() >= 9), 32'h1);
    for (int i = 0; i < 9; i++) begin
      if (i < grant_log.size()) check_val($sformatf("conf_order%0d", i), 32'(grant_log[i]), 32'(i % 3));
    end

    // Parallel banks.
    saw_all = 1'b0;
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'(p*4), 4'hF, 32'h0);
    drain();
    check_val("parallel", 32'(saw_all), 32'h1);

    // Random traffic. Ungranted requests are held stable, as a master would do.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < MP; p++) begin
        if (!req[p] && ($urandom % 4) != 0) begin
          if (($urandom % 10) == 0) begin
            if ($urandom % 2) add[p] = BASE - 32'(4 * (1 + $urandom % 4));
            else              add[p] = BASE + 32'(NB*DEPTH*4) + 32'(4 * ($urandom % 4));
          end else begin
            add[p] = BASE + 32'(4 * ($urandom % 32)) + 32'($urandom % 4);
          end
          req[p]  = 1'b1;
          wen[p]  = 1'($urandom);
          be[p]   = 4'($urandom);
          wdat[p] = $urandom;
        end
      end
      rst = (($urandom % 200) == 0);
      cycle();
      rst = 1'b0;
    end
    req = '0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
